// File: rtl/types_pkg.sv
// types_pkg: shared bus width, access-size and LSU state types.
package types_pkg;
  localparam int DATA_BUS = 32;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} mem_size_e;
  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_e;
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import types_pkg::*;
(
  input  logic [DATA_BUS-1:0] data_i,
  input  logic [1:0]          lane_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  output logic [DATA_BUS-1:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = data_i[{lane_i, 3'b000} +: 8];
  assign h = lane_i[1] ? data_i[31:16] : data_i[15:0];
  assign data_o = (size_i == BYTE) ? {{(DATA_BUS-8){b[7] & ~unsigned_i}}, b} :
                  (size_i == HALF) ? {{(DATA_BUS-16){h[15] & ~unsigned_i}}, h} : data_i;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: M-stage data memory port with alignment check, lane steering and ack timeout.
module load_store_unit
  import types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                MemReqM_i,
  input  logic                MemWriteM_i,
  input  logic [1:0]          MemSizeM_i,
  input  logic                MemUnsignedM_i,
  input  logic [DATA_BUS-1:0] ALU_outM_i,
  input  logic [DATA_BUS-1:0] WriteDataM_i,
  output logic [DATA_BUS-1:0] ReadDataM_o,
  output logic                StallM_o,
  output logic                MisalignedM_o,
  output logic                BusErrorM_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [DATA_BUS-1:0] dmem_addr_o,
  output logic [DATA_BUS-1:0] dmem_wdata_o,
  output logic [3:0]          dmem_be_o,
  input  logic                dmem_ack_i,
  input  logic [DATA_BUS-1:0] dmem_rdata_i
);
  lsu_state_e          state_q, state_d;
  logic                req_q, req_d, we_q, we_d, berr_q, berr_d, uns_q, uns_d;
  logic [DATA_BUS-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, ext_data;
  logic [3:0]          be_q, be_d;
  logic [1:0]          size_q, size_d, lane_q, lane_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                misaligned, start, timeout;

  assign misaligned = (MemSizeM_i == HALF && ALU_outM_i[0]) ||
                      (MemSizeM_i == WORD && ALU_outM_i[1:0] != 2'b00) || MemSizeM_i == 2'b11;
  assign start      = state_q == IDLE && MemReqM_i && !misaligned;
  assign timeout    = cnt_q == 8'(TIMEOUT_CYCLES - 1);

  load_extend u_ext (
    .data_i(dmem_rdata_i), .lane_i(lane_q), .size_i(size_q), .unsigned_i(uns_q), .data_o(ext_data)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    size_d  = size_q;
    lane_d  = lane_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        req_d   = 1'b1;
        we_d    = MemWriteM_i;
        addr_d  = {ALU_outM_i[DATA_BUS-1:2], 2'b00};
        lane_d  = ALU_outM_i[1:0];
        size_d  = MemSizeM_i;
        uns_d   = MemUnsignedM_i;
        cnt_d   = '0;
        be_d    = (MemSizeM_i == BYTE) ? 4'b0001 << ALU_outM_i[1:0] :
                  (MemSizeM_i == HALF) ? (ALU_outM_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_d = (MemSizeM_i == BYTE) ? {4{WriteDataM_i[7:0]}} :
                  (MemSizeM_i == HALF) ? {2{WriteDataM_i[15:0]}} : WriteDataM_i;
      end
      // ack has priority over a timeout landing in the same cycle
      REQ: if (dmem_ack_i || timeout) begin
        state_d = DONE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        rdata_d = (dmem_ack_i && !we_q) ? ext_data : '0;
        berr_d  = !dmem_ack_i;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
      lane_q  <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
    end
  end

  assign ReadDataM_o   = rdata_q;
  assign BusErrorM_o   = berr_q;
  assign MisalignedM_o = state_q == IDLE && MemReqM_i && misaligned;
  assign StallM_o      = start || state_q == REQ;
  assign dmem_req_o    = req_q;
  assign dmem_we_o     = we_q;
  assign dmem_addr_o   = addr_q;
  assign dmem_wdata_o  = wdata_q;
  assign dmem_be_o     = be_q;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning: max cycles waiting for dmem_ack_i before a bus error (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 MemReqM_i  input  1  M-stage instruction is a load or store.
REQ-005 MemWriteM_i  input  1  1 = store, 0 = load.
REQ-006 MemSizeM_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 MemUnsignedM_i  input  1  zero-extend loads (LBU/LHU).
REQ-008 ALU_outM_i  input  DATA_BUS  byte address.
REQ-009 WriteDataM_i  input  DATA_BUS  store data, right-aligned.
REQ-010 ReadDataM_o  output  DATA_BUS  extended load result, toward MEM/WB register.
REQ-011 StallM_o  output  1  freeze F/D/E/M pipeline registers.
REQ-012 MisalignedM_o  output  1  access fault, valid for one cycle.
REQ-013 BusErrorM_o  output  1  timeout fault, valid for one cycle.
REQ-014 dmem_req_o, dmem_we_o  output  1 each  bus request / write strobe.
REQ-015 dmem_addr_o  output  DATA_BUS  word address (bits[1:0] = 0).
REQ-016 dmem_wdata_o  output  DATA_BUS; dmem_be_o  output  4  lane data / byte enables.
REQ-017 dmem_ack_i  input  1; dmem_rdata_i  input  DATA_BUS  completion and read word.

Function
REQ-018 FSM states IDLE, REQ, DONE; all bus outputs registered.
REQ-019 Alignment fault: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
REQ-020 IDLE + MemReqM_i + aligned -> REQ next edge; latch addr, we, be, wdata, size, unsigned; dmem_req_o=1.
REQ-021 IDLE + MemReqM_i + misaligned -> stay IDLE, no bus request, MisalignedM_o=1 combinationally, StallM_o=0.
REQ-022 StallM_o = (IDLE & MemReqM_i & aligned) | REQ; low in DONE so the pipeline advances exactly once.
REQ-023 REQ: dmem_* outputs held stable until dmem_ack_i sampled high; then dmem_req_o=0, go DONE.
REQ-024 Minimum latency: request to DONE = 2 cycles (ack in first REQ cycle).
REQ-025 On ack for a load: ReadDataM_o registered from dmem_rdata_i lane selected by addr[1:0] (byte) or addr[1] (half), sign- or zero-extended per unsigned flag; stores leave ReadDataM_o = 0.
REQ-026 Byte enables: byte 0001<<addr[1:0]; half 0011 / 1100 by addr[1]; word 1111.
REQ-027 Store data replicated to all lanes: byte x4, half x2, word as-is.
REQ-028 8-bit wait counter cleared on entering REQ, increments each REQ cycle without ack.
REQ-029 Counter reaching TIMEOUT_CYCLES without ack -> drop dmem_req_o, ReadDataM_o=0, BusErrorM_o=1 in DONE, go DONE.
REQ-030 Ack and timeout in the same cycle: ack wins, no bus error.
REQ-031 DONE -> IDLE unconditionally; back-to-back accesses cost one IDLE cycle each.
REQ-032 dmem_ack_i in IDLE or DONE ignored.

Reset
REQ-033 rst_n low: state IDLE, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, counter=0, ReadDataM_o=0, fault outputs 0, immediately and asynchronously.
REQ-034 Reset mid-REQ aborts the access; a late ack after release is ignored.

Structure
REQ-035 types_pkg holds DATA_BUS, the MEM_SIZE enum (BYTE, HALF, WORD) and the LSU_STATE enum; no new package.
REQ-036 One sub-module load_extend (combinational lane select + sign/zero extension), reused by REQ-025.

Verification
REQ-037 LB addr 0x103, rdata 0x80FF_1234, ack after 3 cycles -> ReadDataM_o 0xFFFF_FF80, stall for 4 cycles.
REQ-038 SH addr 0x202, data 0x0000_ABCD -> be 1100, wdata 0xABCD_ABCD, addr 0x200, we=1.
REQ-039 LW addr 0x006 -> MisalignedM_o=1 for one cycle, dmem_req_o never asserted, no stall.
REQ-040 LW, no ack, TIMEOUT_CYCLES=4 -> req drops after 4 REQ cycles, BusErrorM_o=1 one cycle, ReadDataM_o=0.
REQ-041 rst_n low during REQ, ack 1 cycle after release -> dmem_req_o=0 at once, state IDLE, ack ignored.
